cmd_sequencer: RTL

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

---
 rtl/cmd_sequencer_pkg.sv | 30 +++
 rtl/cmd_fifo.sv | 60 ++++++
 rtl/cmd_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cmd_sequencer_pkg.sv
// cmd_sequencer_pkg
//   Shared definitions for the command sequencer:
//   - sequencer FSM state encoding
//   - command word layout: opcode in [63:56], argument in [55:0]
//   - default count of legal opcodes
//   - op_legal(): opcode range check against NUM_OPS
package cmd_sequencer_pkg;

    localparam int unsigned CMD_W           = 64;
    localparam int unsigned OP_MSB          = 63;
    localparam int unsigned OP_LSB          = 56;
    localparam int unsigned ARG_MSB         = 55;
    localparam int unsigned ARG_LSB         = 0;
    localparam int unsigned OP_W            = OP_MSB - OP_LSB + 1;
    localparam int unsigned ARG_W           = ARG_MSB - ARG_LSB + 1;
    localparam int unsigned DEFAULT_NUM_OPS = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DISPATCH
    } state_e;

    function automatic logic op_legal(input logic [OP_W-1:0] opcode,
                                      input int unsigned     num_ops);
        return 32'(opcode) < num_ops;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo
//   Synchronous FIFO holding captured command words. The head word is
//   presented combinationally on rd_data_o. Pointers carry one extra wrap
//   bit so full and empty are distinguishable without a counter.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   wr_en_i         write wr_data_i at the tail (caller guarantees room)
//   rd_en_i         pop the head (caller guarantees non-empty)
//   rd_data_o       current head word
//   full_o, empty_o occupancy flags
module cmd_fifo
    import cmd_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = CMD_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer
//   Captures 64-bit command words on a rising edge of cmd_rdy, buffers them
//   in cmd_fifo, range-checks the opcode and dispatches op/arg with an
//   op_valid/op_ack handshake. Sticky error flags report overflow drops,
//   illegal opcodes and (optionally) acknowledge timeouts.
// Configuration:
//   CMD_SEQ_TIMEOUT_EN  when defined, DISPATCH gives up after ACK_TIMEOUT
//                       cycles (ACK_TIMEOUT >= 1) without op_ack and sets
//                       err_to; otherwise DISPATCH waits forever and
//                       err_to is 0.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd, cmd_rdy      command word and receiver "word complete" level
//   op, arg, op_valid dispatched opcode/argument and request
//   op_ack            downstream acknowledge
//   busy              FIFO non-empty or FSM not idle
//   err_ovf/op/to     sticky error flags, cleared by err_clr pulse
module cmd_sequencer
    import cmd_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned NUM_OPS     = DEFAULT_NUM_OPS,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CMD_W-1:0] cmd,
    input  logic             cmd_rdy,
    output logic [OP_W-1:0]  op,
    output logic [ARG_W-1:0] arg,
    output logic             op_valid,
    input  logic             op_ack,
    output logic             busy,
    output logic             err_ovf,
    output logic             err_op,
    output logic             err_to,
    input  logic             err_clr
);

    logic             rdy_q, armed_q;
    logic             capture, fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [CMD_W-1:0] fifo_head;
    state_e           state_q;
    logic [OP_W-1:0]  op_q;
    logic [ARG_W-1:0] arg_q;
    logic             valid_q, err_ovf_q, err_op_q;
    logic             ovf_set, op_set, to_set;

    // armed_q stays low after reset until cmd_rdy has been seen low, so a
    // level already high at reset release does not count as a new word.
    assign capture = cmd_rdy & ~rdy_q & armed_q;
    assign fifo_rd = (state_q == ST_LOAD);
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign fifo_wr = capture & (~fifo_full | fifo_rd);
    assign ovf_set = capture & fifo_full & ~fifo_rd;
    assign op_set  = (state_q == ST_CHECK) && !op_legal(op_q, NUM_OPS);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (fifo_wr),
        .wr_data_i (cmd),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

`ifdef CMD_SEQ_TIMEOUT_EN
    localparam int unsigned     TO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] to_cnt_q;
    logic            err_to_q;

    // Counter equals the number of DISPATCH cycles already spent.
    assign to_set = (state_q == ST_DISPATCH) && !op_ack && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            err_to_q <= 1'b0;
        end else begin
            if (state_q == ST_CHECK)         to_cnt_q <= '0;
            else if (state_q == ST_DISPATCH) to_cnt_q <= to_cnt_q + TO_ONE;
            err_to_q <= err_clr ? 1'b0 : (err_to_q | to_set);
        end
    end

    assign err_to = err_to_q;
`else
    // ACK_TIMEOUT has no effect in this build.
    logic unused_ack_timeout;
    assign unused_ack_timeout = (ACK_TIMEOUT == 0);
    assign to_set = 1'b0;
    assign err_to = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            armed_q   <= 1'b0;
            state_q   <= ST_IDLE;
            op_q      <= '0;
            arg_q     <= '0;
            valid_q   <= 1'b0;
            err_ovf_q <= 1'b0;
            err_op_q  <= 1'b0;
        end else begin
            rdy_q     <= cmd_rdy;
            armed_q   <= armed_q | ~cmd_rdy;
            err_ovf_q <= err_clr ? 1'b0 : (err_ovf_q | ovf_set);
            err_op_q  <= err_clr ? 1'b0 : (err_op_q | op_set);
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    op_q    <= fifo_head[OP_MSB:OP_LSB];
                    arg_q   <= fifo_head[ARG_MSB:ARG_LSB];
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (op_legal(op_q, NUM_OPS)) begin
                        valid_q <= 1'b1;
                        state_q <= ST_DISPATCH;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DISPATCH: begin
                    if (op_ack || to_set) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign op       = op_q;
    assign arg      = arg_q;
    assign op_valid = valid_q;
    assign err_ovf  = err_ovf_q;
    assign err_op   = err_op_q;
    assign busy     = !fifo_empty || (state_q != ST_IDLE);

endmodule
